ttt_game_ctrl: RTL and testbench
================================

Name: ttt_game_ctrl

Overview:
Game sequencer for the 3x3 tic-tac-toe display path. Accepts debounced keypad events, arbitrates turns between player 1 and player 2, and owns the 18-bit board register. Detects win and draw, and produces a blink-masked board copy. Its board_disp output feeds the dot-matrix display block; its turn output feeds the display's row-offset input.

Parameters:
BLINK_DIV, 12500000, clk cycles per blink half-period; 0.5 s at 25 MHz; minimum 2
FIRST_PLAYER, 1, cell code of the player who moves first after reset or restart (1 or 2)

Ports:
clk  input  1  system clock, 25 MHz
rst  input  1  asynchronous, active-high reset
key_valid  input  1  one-cycle pulse; key_code valid
key_code  input  4  0-8 = cell index; 15 = restart; 9-14 = ignored
board  output  18  true board; cell k at bits [2k+1:2k]; 0 = empty, 1 = P1, 2 = P2, 3 never written
board_disp  output  18  board with winning cells forced to 0 while blink=1
turn  output  1  0 = P1 to move, 1 = P2 to move
game_over  output  1  high in WIN or DRAW
winner  output  2  0 = none/draw, 1 = P1, 2 = P2
win_mask  output  9  bit k set if cell k lies on a completed line
err  output  1  one-cycle pulse on a rejected move

Behaviour:
- Reset values:
  - board = 0, board_disp = 0, win_mask = 0
  - turn = FIRST_PLAYER-1
  - game_over = 0, winner = 0, err = 0
  - state = PLAY, move_cnt = 0
  - blink = 0, blink counter = 0
- All outputs are registered. Reset acts immediately, including mid-CHECK or mid-blink.
- FSM states: PLAY, CHECK, WIN, DRAW.
- PLAY, key_valid with code 0-8:
  - Cell empty: write cell = turn+1, move_cnt += 1, go to CHECK. Board changes on the cycle after key_valid.
  - Cell occupied: no write; err pulses the next cycle; stay in PLAY.
- CHECK (exactly 1 cycle): evaluate the 8 lines on the registered board: rows 0-2/3-5/6-8, columns 0,3,6 / 1,4,7 / 2,5,8, diagonals 0,4,8 / 2,4,6.
  - Any line of three equal non-zero cells: winner = mover, win_mask = OR of all completed lines (a double line is legal), go to WIN.
  - Else if move_cnt = 9: go to DRAW.
  - Else: toggle turn, go to PLAY.
  - game_over, turn and winner update 2 cycles after key_valid.
- key_valid with code 0-8 during CHECK: dropped silently, no err.
- WIN/DRAW:
  - code 0-8 pulses err; board frozen; turn not toggled.
  - game_over = 1 in both states.
- Restart (code 15), accepted in any state including CHECK:
  - next cycle: board = 0, move_cnt = 0, turn = FIRST_PLAYER-1, winner = 0, win_mask = 0, blink = 0, counter = 0, state = PLAY.
- Codes 9-14: ignored in all states, no err.
- Blink:
  - The counter runs only in WIN. On reaching BLINK_DIV-1 it wraps to 0 and toggles blink.
  - board_disp = board with cells in win_mask cleared when blink = 1; otherwise board_disp = board.
  - board_disp updates one cycle after board/blink changes.
  - Outside WIN, blink is held at 0.
- move_cnt is 4 bits and saturates at 9. Reaching 9 is only possible through legal writes.

Decomposition:
- Shared package ttt_pkg holds:
  - cell codes CELL_EMPTY = 0, CELL_P1 = 1, CELL_P2 = 2
  - KEY_RESTART = 15
  - FSM state encoding
  - the 8 win-line cell-index triples as constants
- One sub-module: ttt_win_detect, purely combinational. Takes the 18-bit board; returns win (1), win_player (2) and win_mask (9). It is reused later for a computer-opponent block.

Test Plan:
- Reset, then keys 4,0,8,2,1,7 -> cells 4,8,1 = 1 and 0,2,7 = 2; turn = 0 after the last CHECK; game_over = 0.
- Keys 0,3,1,4,2 -> after key 2: board cells 0,1,2 = 1 at +1 cycle; state WIN, winner = 1, win_mask = 9'b000000111 at +2 cycles; a further key 5 -> err pulse, board unchanged.
- Key 4 twice -> second key gives err = 1 for exactly one cycle; turn still 1; board[9:8] = 1.
- Full draw sequence 0,1,2,4,3,5,7,6,8 -> DRAW, game_over = 1, winner = 0, win_mask = 0.
- Win with BLINK_DIV = 4 -> board_disp alternates winning cells cleared/shown every 4 cycles. Key 15 mid-blink -> next cycle board = 0, board_disp = 0, state PLAY, turn = 0.
- key_valid with code 5 in the CHECK cycle -> ignored, no err. Assert rst during CHECK -> all outputs at reset values immediately (asynchronous).

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, key codes, FSM states and the
// eight winning lines.
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY   = 2'd0;
   localparam logic [1:0] CELL_P1      = 2'd1;
   localparam logic [1:0] CELL_P2      = 2'd2;

   localparam logic [3:0] KEY_RESTART  = 4'd15;
   localparam logic [3:0] KEY_MAX_CELL = 4'd8;

   localparam logic [3:0] MOVES_FULL   = 4'd9;

   localparam int unsigned N_LINES = 8;

   typedef enum logic [1:0] {
      PLAY  = 2'd0,
      CHECK = 2'd1,
      WIN   = 2'd2,
      DRAW  = 2'd3
   } state_t;

   // Each entry is one line of three cell indices (rows, columns, diagonals).
   localparam logic [N_LINES-1:0][2:0][3:0] WIN_LINES = {
      {4'd2, 4'd4, 4'd6},
      {4'd0, 4'd4, 4'd8},
      {4'd2, 4'd5, 4'd8},
      {4'd1, 4'd4, 4'd7},
      {4'd0, 4'd3, 4'd6},
      {4'd6, 4'd7, 4'd8},
      {4'd3, 4'd4, 4'd5},
      {4'd0, 4'd1, 4'd2}
   };

   // Two-bit code of cell idx within an 18-bit board.
   function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] idx);
      return b[{idx, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational win detector: flags any completed line, reports its owner and
// the union of all cells lying on completed lines.
module ttt_win_detect
   import ttt_pkg::*;
(
   input  logic [17:0] board,
   output logic        win,
   output logic [1:0]  win_player,
   output logic [8:0]  win_mask
);

   logic [1:0] ca, cb, cc;

   // Scan all eight lines; a double line simply ORs into the mask.
   always_comb begin
      win        = 1'b0;
      win_player = CELL_EMPTY;
      win_mask   = '0;
      ca         = CELL_EMPTY;
      cb         = CELL_EMPTY;
      cc         = CELL_EMPTY;
      for (int unsigned l = 0; l < N_LINES; l++) begin
         ca = cell_of(board, WIN_LINES[l[2:0]][0]);
         cb = cell_of(board, WIN_LINES[l[2:0]][1]);
         cc = cell_of(board, WIN_LINES[l[2:0]][2]);
         if (ca != CELL_EMPTY && ca == cb && ca == cc) begin
            win        = 1'b1;
            win_player = ca;
            win_mask[WIN_LINES[l[2:0]][0]] = 1'b1;
            win_mask[WIN_LINES[l[2:0]][1]] = 1'b1;
            win_mask[WIN_LINES[l[2:0]][2]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: turn arbitration, board ownership, win/draw
// detection and blink-masked display copy of the board.
module ttt_game_ctrl
   import ttt_pkg::*;
#(
   parameter int unsigned BLINK_DIV    = 12500000,
   parameter int unsigned FIRST_PLAYER = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [17:0] board,
   output logic [17:0] board_disp,
   output logic        turn,
   output logic        game_over,
   output logic [1:0]  winner,
   output logic [8:0]  win_mask,
   output logic        err
);

   localparam logic             FIRST_TURN = (FIRST_PLAYER == 2);
   localparam int unsigned      CNT_W      = $clog2(BLINK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BLINK_DIV - 1);

   state_t           state, state_nxt;
   logic [3:0]       move_cnt, move_cnt_nxt;
   logic [17:0]      board_nxt, disp_nxt;
   logic             turn_nxt, err_nxt, blink, blink_nxt;
   logic [1:0]       winner_nxt;
   logic [8:0]       win_mask_nxt;
   logic [CNT_W-1:0] blink_cnt, blink_cnt_nxt;

   logic             det_win;
   logic [1:0]       det_player;
   logic [8:0]       det_mask;
   logic             is_cell, is_restart;

   assign is_cell    = key_valid && (key_code <= KEY_MAX_CELL);
   assign is_restart = key_valid && (key_code == KEY_RESTART);

   ttt_win_detect u_win_detect (
      .board      (board),
      .win        (det_win),
      .win_player (det_player),
      .win_mask   (det_mask)
   );

   // Next-state and next-output logic; restart overrides every state.
   always_comb begin
      state_nxt     = state;
      board_nxt     = board;
      move_cnt_nxt  = move_cnt;
      turn_nxt      = turn;
      winner_nxt    = winner;
      win_mask_nxt  = win_mask;
      err_nxt       = 1'b0;
      blink_nxt     = 1'b0;
      blink_cnt_nxt = '0;
      if (is_restart) begin
         state_nxt    = PLAY;
         board_nxt    = '0;
         move_cnt_nxt = '0;
         turn_nxt     = FIRST_TURN;
         winner_nxt   = CELL_EMPTY;
         win_mask_nxt = '0;
      end else begin
         unique case (state)
            PLAY: begin
               if (is_cell) begin
                  if (cell_of(board, key_code) == CELL_EMPTY) begin
                     board_nxt[{key_code, 1'b0} +: 2] = turn ? CELL_P2 : CELL_P1;
                     if (move_cnt != MOVES_FULL) move_cnt_nxt = move_cnt + 4'd1;
                     state_nxt = CHECK;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end
            CHECK: begin
               if (det_win) begin
                  state_nxt    = WIN;
                  winner_nxt   = det_player;
                  win_mask_nxt = det_mask;
               end else if (move_cnt == MOVES_FULL) begin
                  state_nxt = DRAW;
               end else begin
                  turn_nxt  = ~turn;
                  state_nxt = PLAY;
               end
            end
            WIN: begin
               err_nxt = is_cell;
               if (blink_cnt == CNT_LAST) begin
                  blink_cnt_nxt = '0;
                  blink_nxt     = ~blink;
               end else begin
                  blink_cnt_nxt = blink_cnt + CNT_W'(1);
                  blink_nxt     = blink;
               end
            end
            DRAW: begin
               err_nxt = is_cell;
            end
            default: ;
         endcase
      end
   end

   // Display copy lags the board by a cycle, except restart blanks it at once.
   always_comb begin
      disp_nxt = board;
      if (blink) begin
         for (int unsigned k = 0; k < 9; k++) begin
            if (win_mask[k[3:0]]) disp_nxt[{k[3:0], 1'b0} +: 2] = CELL_EMPTY;
         end
      end
      if (is_restart) disp_nxt = '0;
   end

   // State and registered outputs, asynchronously reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= PLAY;
         board      <= '0;
         board_disp <= '0;
         move_cnt   <= '0;
         turn       <= FIRST_TURN;
         winner     <= CELL_EMPTY;
         win_mask   <= '0;
         err        <= 1'b0;
         game_over  <= 1'b0;
         blink      <= 1'b0;
         blink_cnt  <= '0;
      end else begin
         state      <= state_nxt;
         board      <= board_nxt;
         board_disp <= disp_nxt;
         move_cnt   <= move_cnt_nxt;
         turn       <= turn_nxt;
         winner     <= winner_nxt;
         win_mask   <= win_mask_nxt;
         err        <= err_nxt;
         game_over  <= (state_nxt == WIN) || (state_nxt == DRAW);
         blink      <= blink_nxt;
         blink_cnt  <= blink_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed scenarios plus random key
// streams checked against a cell-array game model.
module tb_ttt_game_ctrl;

   localparam int unsigned BLINK_DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [17:0] board, board_disp;
   logic        turn, game_over, err;
   logic [1:0]  winner;
   logic [8:0]  win_mask;

   ttt_game_ctrl #(.BLINK_DIV(BLINK_DIV), .FIRST_PLAYER(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .board      (board),
      .board_disp (board_disp),
      .turn       (turn),
      .game_over  (game_over),
      .winner     (winner),
      .win_mask   (win_mask),
      .err        (err)
   );

   // 25 MHz-style free-running clock (period is arbitrary in simulation).
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Game model: plain cell array, player to move, status 0=play 1=won 2=draw.
   int         m_cell [9];
   int         m_cur;
   int         m_status;
   int         m_winner;
   int         m_moves;
   logic [8:0] m_mask;
   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_restart();
      for (int k = 0; k < 9; k++) m_cell[k] = 0;
      m_cur    = 1;
      m_status = 0;
      m_winner = 0;
      m_moves  = 0;
      m_mask   = '0;
   endfunction

   function automatic logic m_apply(input int code);
      int  a, b, c;
      logic won;
      if (code == 15) begin
         m_restart();
         return 1'b0;
      end
      if (code > 8) return 1'b0;
      if (m_status != 0 || m_cell[code] != 0) return 1'b1;
      m_cell[code] = m_cur;
      m_moves++;
      won = 1'b0;
      for (int l = 0; l < 8; l++) begin
         a = m_cell[lines[l][0]];
         b = m_cell[lines[l][1]];
         c = m_cell[lines[l][2]];
         if (a != 0 && a == b && a == c) begin
            won = 1'b1;
            for (int j = 0; j < 3; j++) m_mask = m_mask | (9'd1 << lines[l][j]);
         end
      end
      if (won) begin
         m_status = 1;
         m_winner = m_cur;
      end else if (m_moves == 9) begin
         m_status = 2;
      end else begin
         m_cur = 3 - m_cur;
      end
      return 1'b0;
   endfunction

   function automatic logic [17:0] m_board();
      logic [17:0] r = '0;
      for (int k = 0; k < 9; k++) r = r | (18'(m_cell[k]) << (2 * k));
      return r;
   endfunction

   function automatic logic [17:0] m_board_blanked();
      logic [17:0] r = '0;
      for (int k = 0; k < 9; k++)
         if (m_mask[k] == 1'b0) r = r | (18'(m_cell[k]) << (2 * k));
      return r;
   endfunction

   // One-cycle key pulse, then checks at +1 and +2 cycles against the model.
   task automatic press(input int code);
      logic exp_err;
      exp_err   = m_apply(code);
      key_valid = 1'b1;
      key_code  = 4'(code);
      @(posedge clk); #1;
      key_valid = 1'b0;
      chk("err_p1", 32'(err), 32'(exp_err));
      chk("board_p1", 32'(board), 32'(m_board()));
      if (code == 15) chk("disp_restart", 32'(board_disp), 32'd0);
      @(posedge clk); #1;
      chk("err_p2", 32'(err), 32'd0);
      chk("board_p2", 32'(board), 32'(m_board()));
      chk("turn", 32'(turn), 32'(m_cur - 1));
      chk("game_over", 32'(game_over), 32'(m_status != 0));
      chk("winner", 32'(winner), (m_status == 1) ? 32'(m_winner) : 32'd0);
      chk("win_mask", 32'(win_mask), 32'(m_mask));
      if (m_status != 1) chk("board_disp", 32'(board_disp), 32'(m_board()));
   endtask

   int seq_a [6] = '{4, 0, 8, 2, 1, 7};
   int seq_w [5] = '{0, 3, 1, 4, 2};
   int seq_d [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

   initial begin
      int r, code;
      logic dummy;

      // Reset state
      rst = 1'b1; key_valid = 1'b0; key_code = 4'd0;
      m_restart();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_board", 32'(board), 32'd0);
      chk("rst_disp", 32'(board_disp), 32'd0);
      chk("rst_turn", 32'(turn), 32'd0);
      chk("rst_over", 32'(game_over), 32'd0);
      chk("rst_winner", 32'(winner), 32'd0);
      chk("rst_mask", 32'(win_mask), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Alternating moves without a win
      foreach (seq_a[i]) press(seq_a[i]);
      chk("seqA_board", 32'(board), 32'h18126);
      chk("seqA_turn", 32'(turn), 32'd0);
      chk("seqA_over", 32'(game_over), 32'd0);

      // Top-row win for P1, then a rejected move while frozen
      press(15);
      foreach (seq_w[i]) press(seq_w[i]);
      chk("win_winner", 32'(winner), 32'd1);
      chk("win_mask_row", 32'(win_mask), 32'h007);
      press(5);
      chk("win_frozen", 32'(board), 32'h295);

      // Same cell twice
      press(15);
      press(4);
      press(4);
      chk("dup_turn", 32'(turn), 32'd1);
      chk("dup_cell4", 32'(board[9:8]), 32'd1);

      // Full-board draw
      press(15);
      foreach (seq_d[i]) press(seq_d[i]);
      chk("draw_over", 32'(game_over), 32'd1);
      chk("draw_winner", 32'(winner), 32'd0);
      chk("draw_mask", 32'(win_mask), 32'd0);

      // Win, then observe blink phases of the display copy
      press(15);
      foreach (seq_w[i]) press(seq_w[i]);
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         chk("blink_disp", 32'(board_disp),
             (((n - 1) / 4) % 2 == 1) ? 32'(m_board_blanked()) : 32'(m_board()));
      end
      chk("blink_blanked_val", 32'(m_board_blanked()), 32'h280);
      press(15);
      chk("restart_turn", 32'(turn), 32'd0);
      chk("restart_over", 32'(game_over), 32'd0);

      // A cell key arriving during CHECK is dropped
      dummy     = m_apply(0);
      key_valid = 1'b1; key_code = 4'd0;
      @(posedge clk); #1;
      key_code  = 4'd5;
      @(posedge clk); #1;
      key_valid = 1'b0;
      chk("chkdrop_err", 32'(err), 32'd0);
      chk("chkdrop_board", 32'(board), 32'(m_board()));
      chk("chkdrop_turn", 32'(turn), 32'd1);
      @(posedge clk); #1;
      chk("chkdrop_err2", 32'(err), 32'd0);

      // Asynchronous reset while in CHECK
      press(15);
      key_valid = 1'b1; key_code = 4'd1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      chk("arst_pre_board", 32'(board), 32'h4);
      rst = 1'b1;
      #1;
      chk("arst_board", 32'(board), 32'd0);
      chk("arst_disp", 32'(board_disp), 32'd0);
      chk("arst_turn", 32'(turn), 32'd0);
      chk("arst_over", 32'(game_over), 32'd0);
      chk("arst_winner", 32'(winner), 32'd0);
      chk("arst_mask", 32'(win_mask), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      @(negedge clk); rst = 1'b0;
      m_restart();
      @(posedge clk); #1;

      // Random key streams
      for (int g = 0; g < 10; g++) begin
         press(15);
         for (int s = 0; s < 14; s++) begin
            r = $urandom_range(0, 19);
            if (r < 15)      code = $urandom_range(0, 8);
            else if (r < 19) code = $urandom_range(9, 14);
            else             code = 15;
            press(code);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
